pcie_vc_arbiter: RTL and testbench
==================================

PCIE_VC_ARBITER -- requirements
Module: pcie_vc_arbiter

Interface
REQ-001 Parameter DATA_W, default 5: payload width in bits.
REQ-002 Parameter NUM_VC, default 2: number of virtual channels; legal values are 2, 4 and 8. Localparam VC_W = log2(NUM_VC).
REQ-003 Parameter ADDR_WIDTH, default 3: per-VC FIFO address width; DEPTH = 2^ADDR_WIDTH entries.
REQ-004 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-007 Port data_in, input, DATA_W+VC_W bits: the VC_W MSBs select the VC; the DATA_W LSBs are the payload.
REQ-008 Port umbralA, input, ADDR_WIDTH+1 bits: almost-full threshold, shared by all VCs.
REQ-009 Port umbralB, input, ADDR_WIDTH+1 bits: almost-empty threshold, shared by all VCs.
REQ-010 Port out_ready, input, 1 bit: the downstream side accepts out_data this cycle.
REQ-011 Port out_data, output, DATA_W bits: payload of the granted word.
REQ-012 Port out_vc, output, VC_W bits: VC index of the word on out_data.
REQ-013 Port out_valid, output, 1 bit: out_data and out_vc hold a word.
REQ-014 Port pause, output, NUM_VC bits: per-VC flow-control stop level.
REQ-015 Port continue, output, NUM_VC bits: per-VC one-cycle resume pulse.
REQ-016 Port overflow, output, NUM_VC bits: per-VC one-cycle pulse when a write is dropped.

Function
REQ-017 Each VC has its own FIFO of DEPTH entries with an occupancy count in the range 0..DEPTH; read and write pointers wrap modulo DEPTH.
REQ-018 Write rule: valid_in=1 and count[v]<DEPTH stores the payload in FIFO v at the edge.
REQ-019 If count[v]=DEPTH, the write is dropped and overflow[v]=1 for the next cycle, even if FIFO v is popped in the same cycle.
REQ-020 Output stage is a single register. Pop condition: out_valid=0, or out_valid=1 and out_ready=1.
REQ-021 On a pop edge with at least one non-empty VC, the arbiter grants one VC, pops its head into out_data/out_vc, and sets out_valid=1.
REQ-022 On a pop edge with all VCs empty, out_valid goes to 0.
REQ-023 Holding rule: when out_valid=1 and out_ready=0, out_data, out_vc and out_valid hold their values.
REQ-024 Latency: a word written at edge k into an empty block with the output register free appears on out_data after edge k+1. The pop uses registered counts, so there is no same-cycle bypass.
REQ-025 Default arbitration is round-robin: grant the first non-empty VC after last_grant, cyclically. last_grant updates on every grant.
REQ-026 Simultaneous write and pop on the same VC leave count[v] unchanged; both operations take effect.
REQ-027 pause[v] sets to 1 at the edge where the next count[v] is >= umbralA.
REQ-028 pause[v] clears at the edge where the next count[v] is <= umbralB; otherwise it holds.
REQ-029 If umbralB >= umbralA, pause[v] equals (count[v] >= umbralA), with no hysteresis.
REQ-030 continue[v]=1 for exactly one cycle following the edge where pause[v] falls from 1 to 0.
REQ-031 pause and continue are advisory only: writes are never blocked by pause, only by a full FIFO.

Reset
REQ-032 reset=1 asynchronously clears all pointers and counts, out_valid, out_data, out_vc, pause, continue and overflow to 0.
REQ-033 Reset sets last_grant to NUM_VC-1, so VC0 wins the first arbitration.
REQ-034 Reset asserted mid-operation discards all stored words. The first edge after reset deassertion behaves as from an empty block.

Configuration
REQ-035 Macro PCIE_VC_STRICT_PRIO_EN, when defined: the arbiter grants the lowest-index non-empty VC (VC0 highest priority), and last_grant is unused.
REQ-036 Without PCIE_VC_STRICT_PRIO_EN, round-robin arbitration per REQ-025 applies.

Verification
REQ-037 Latency check (defaults, out_ready=1): write 0x15 to VC1 once. Required: out_valid=1, out_data=0x15, out_vc=1 one cycle after the write edge, then out_valid=0.
REQ-038 Fairness check: preload 3 words each into VC0 and VC1 with out_ready=0, then raise out_ready. Required: out_vc sequence 0,1,0,1,0,1. With PCIE_VC_STRICT_PRIO_EN the sequence is 0,0,0,1,1,1.
REQ-039 Threshold check (umbralA=6, umbralB=2): fill VC0 to 6 with out_ready=0. Required: pause[0]=1 at count 6.
REQ-039a Continuing REQ-039, drain VC0. Required: pause[0] stays 1 through counts 5..3, clears at count 2, and continue[0] pulses for exactly one cycle.
REQ-040 Overflow check: write 9 words to VC1 with out_ready=0. Required: count 8, overflow[1] pulses once on the 9th write, stored words intact.
REQ-041 Full-plus-pop check: VC1 full and a pop plus a write in the same cycle. Required: the write is dropped, overflow[1]=1, count becomes 7.
REQ-042 Reset check: assert reset mid-stream, asynchronously between edges. Required: all outputs 0 immediately; after release, the first written word appears with out_vc equal to its own VC.

Source files
------------

// File: rtl/pcie_vc_arbiter.sv
// Per-VC FIFOs feeding a single registered output via round-robin arbitration, with
// pause/continue hysteresis flow control. Define PCIE_VC_STRICT_PRIO_EN for fixed priority.
module pcie_vc_arbiter #(
    parameter int unsigned DATA_W     = 5,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned ADDR_WIDTH = 3,
    localparam int unsigned VC_W      = $clog2(NUM_VC),
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [DATA_W+VC_W-1:0] data_in,
    input  logic [ADDR_WIDTH:0]    umbralA,
    input  logic [ADDR_WIDTH:0]    umbralB,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [VC_W-1:0]        out_vc,
    output logic                   out_valid,
    output logic [NUM_VC-1:0]      pause,
    output logic [NUM_VC-1:0]      continue_o,
    output logic [NUM_VC-1:0]      overflow
);

    logic [DATA_W-1:0]     mem_q    [NUM_VC][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
    logic [ADDR_WIDTH:0]   cnt_q    [NUM_VC];
    logic [ADDR_WIDTH:0]   cnt_d    [NUM_VC];

    logic [VC_W-1:0]   wr_vc;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_VC-1:0] nonempty, wr_en, rd_en;
    logic [NUM_VC-1:0] pause_d, cont_d, ovf_d;
    logic [VC_W-1:0]   grant;
    logic              any_req, pop_ok;

    assign wr_vc   = data_in[DATA_W+VC_W-1 -: VC_W];
    assign wr_data = data_in[DATA_W-1:0];
    assign pop_ok  = !out_valid || out_ready;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            nonempty[v] = (cnt_q[v] != '0);
        end
    end

`ifdef PCIE_VC_STRICT_PRIO_EN
    always_comb begin
        grant   = '0;
        any_req = |nonempty;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (nonempty[i]) grant = VC_W'(i);
        end
    end
`else
    logic [VC_W-1:0] last_grant_q;
    logic [VC_W-1:0] cand;

    // Scan starts just after the last winner; NUM_VC is a power of two so the sum wraps.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            cand = last_grant_q + VC_W'(i);
            if (!any_req && nonempty[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= VC_W'(NUM_VC - 1);
        end else if (pop_ok && any_req) begin
            last_grant_q <= grant;
        end
    end
`endif

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_en[v] = valid_in && (wr_vc == VC_W'(v)) && (cnt_q[v] != (ADDR_WIDTH+1)'(DEPTH));
            ovf_d[v] = valid_in && (wr_vc == VC_W'(v)) && (cnt_q[v] == (ADDR_WIDTH+1)'(DEPTH));
            rd_en[v] = pop_ok && any_req && (grant == VC_W'(v));
            cnt_d[v] = cnt_q[v] + (ADDR_WIDTH+1)'(wr_en[v]) - (ADDR_WIDTH+1)'(rd_en[v]);
            // Set wins over clear, which collapses to a plain compare when umbralB >= umbralA.
            if (cnt_d[v] >= umbralA) begin
                pause_d[v] = 1'b1;
            end else if (cnt_d[v] <= umbralB) begin
                pause_d[v] = 1'b0;
            end else begin
                pause_d[v] = pause[v];
            end
            cont_d[v] = pause[v] && !pause_d[v];
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            pause      <= '0;
            continue_o <= '0;
            overflow   <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + ADDR_WIDTH'(1);
                if (rd_en[v]) rd_ptr_q[v] <= rd_ptr_q[v] + ADDR_WIDTH'(1);
                cnt_q[v] <= cnt_d[v];
            end
            pause      <= pause_d;
            continue_o <= cont_d;
            overflow   <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc    <= '0;
        end else if (pop_ok) begin
            out_valid <= any_req;
            if (any_req) begin
                out_data <= mem_q[grant][rd_ptr_q[grant]];
                out_vc   <= grant;
            end
        end
    end

endmodule

// File: tb/tb_pcie_vc_arbiter.sv
// Randomized and directed bench for pcie_vc_arbiter against a queue-based reference model.
module tb_pcie_vc_arbiter;

    localparam int unsigned DATA_W     = 5;
    localparam int unsigned NUM_VC     = 2;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned VC_W       = $clog2(NUM_VC);
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    logic                   clk, reset, valid_in, out_ready, out_valid;
    logic [DATA_W+VC_W-1:0] data_in;
    logic [ADDR_WIDTH:0]    umbralA, umbralB;
    logic [DATA_W-1:0]      out_data;
    logic [VC_W-1:0]        out_vc;
    logic [NUM_VC-1:0]      pause, continue_o, overflow;

    pcie_vc_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_VC    (NUM_VC),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .umbralA   (umbralA),
        .umbralB   (umbralB),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_vc    (out_vc),
        .out_valid (out_valid),
        .pause     (pause),
        .continue_o(continue_o),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per VC, the output register, and the arbitration pointer.
    logic [DATA_W-1:0] mq [NUM_VC][$];
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_vc, m_last;
    logic [NUM_VC-1:0] m_pause, m_cont, m_ovf;
    int                ua, ub;

    task automatic model_reset();
        for (int c = 0; c < NUM_VC; c++) mq[c].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_vc    = 0;
        m_last  = NUM_VC - 1;
        m_pause = '0;
        m_cont  = '0;
        m_ovf   = '0;
    endtask

    task automatic model_step(input logic v, input int vc, input logic [DATA_W-1:0] d,
                              input logic rdy);
        int  g;
        bit  found, full, old_p;
        full  = (mq[vc].size() == DEPTH);
        m_ovf = '0;
        if (v && full) m_ovf[vc] = 1'b1;
        if (!m_valid || rdy) begin
            found = 0;
            g     = 0;
            for (int i = 1; i <= NUM_VC; i++) begin
`ifdef PCIE_VC_STRICT_PRIO_EN
                int c = i - 1;
`else
                int c = (m_last + i) % NUM_VC;
`endif
                if (!found && mq[c].size() > 0) begin
                    found = 1;
                    g     = c;
                end
            end
            if (found) begin
                m_data  = mq[g].pop_front();
                m_vc    = g;
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (v && !full) mq[vc].push_back(d);
        for (int c = 0; c < NUM_VC; c++) begin
            old_p = m_pause[c];
            if (mq[c].size() >= ua) m_pause[c] = 1'b1;
            else if (mq[c].size() <= ub) m_pause[c] = 1'b0;
            m_cont[c] = old_p && !m_pause[c];
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_vc", 32'(out_vc), 32'(m_vc));
        end
        check("pause", 32'(pause), 32'(m_pause));
        check("continue", 32'(continue_o), 32'(m_cont));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic v, input int vc, input logic [DATA_W-1:0] d, input logic rdy);
        valid_in  = v;
        data_in   = {VC_W'(vc), d};
        out_ready = rdy;
        umbralA   = (ADDR_WIDTH+1)'(ua);
        umbralB   = (ADDR_WIDTH+1)'(ub);
        model_step(v, vc, d, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_vc"}, 32'(out_vc), 32'd0);
        check({tag, "_pause"}, 32'(pause), 32'd0);
        check({tag, "_cont"}, 32'(continue_o), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    int exp_seq [6];
    int cont_seen;

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        ua        = 8;
        ub        = 0;
        umbralA   = (ADDR_WIDTH+1)'(ua);
        umbralB   = (ADDR_WIDTH+1)'(ub);
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Latency: a single write appears one edge later, then the output empties.
        cycle(1'b1, 1, 5'h15, 1'b1);
        check("lat_early_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 0, '0, 1'b1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h15);
        check("lat_vc", 32'(out_vc), 32'd1);
        cycle(1'b0, 0, '0, 1'b1);
        check("lat_after", 32'(out_valid), 32'd0);

        // Fairness: three words per VC preloaded while stalled.
`ifdef PCIE_VC_STRICT_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 0, DATA_W'(i), 1'b0);
            cycle(1'b1, 1, DATA_W'(i + 8), 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_vc", 32'(out_vc), 32'(exp_seq[i]));
            cycle(1'b0, 0, '0, 1'b1);
        end

        // Thresholds: fill VC0 to 6 behind a held word, then drain.
        do_reset();
        ua = 6;
        ub = 2;
        cycle(1'b1, 1, 5'h1f, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 0, DATA_W'(i + 1), 1'b0);
        check("thr_pause_set", 32'(pause[0]), 32'd1);
        cont_seen = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 0, '0, 1'b1);
            cont_seen += int'(continue_o[0]);
        end
        check("thr_pause_clr", 32'(pause[0]), 32'd0);
        check("thr_cont_once", 32'(cont_seen), 32'd1);

        // Overflow and full-plus-pop on VC1.
        do_reset();
        ua = 8;
        ub = 0;
        cycle(1'b1, 0, 5'h0a, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1, DATA_W'(i + 16), 1'b0);
        check("ovf_9th", 32'(overflow), 32'h2);
        cycle(1'b1, 1, 5'h07, 1'b1);
        check("ovf_pop", 32'(overflow), 32'h2);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, '0, 1'b1);

        // Randomized traffic with varying thresholds and backpressure.
        for (int p = 0; p < 10; p++) begin
            int rdy_pct;
            ua      = $urandom_range(0, DEPTH);
            ub      = $urandom_range(0, DEPTH);
            rdy_pct = (p % 2 == 0) ? 20 : 80;
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < 75, $urandom_range(0, NUM_VC - 1),
                      DATA_W'($urandom), $urandom_range(0, 99) < rdy_pct);
            end
        end

        // Asynchronous reset mid-stream, then a fresh word reports its own VC.
        for (int i = 0; i < 8; i++) cycle(1'b1, i % NUM_VC, DATA_W'(i), 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1, 5'h0c, 1'b1);
        cycle(1'b0, 0, '0, 1'b1);
        check("rst_first_vc", 32'(out_vc), 32'd1);
        check("rst_first_data", 32'(out_data), 32'h0c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
